regfile_seq_ctrl: RTL

Multi-cycle sequencer for the CPU's single shared register-file read mux and the ALU. It accepts one decoded instruction per start pulse and steps the read mux through destination and source operands. It launches the ALU and issues a one-hot writeback. It sits between the decoder and the datapath, and is the only driver of the read-mux 5-bit select (0 = none, n+1 = rn).

---
 rtl/regfile_seq_ctrl_pkg.sv | 34 +++
 rtl/regfile_seq_ctrl_if.sv | 34 +++
 rtl/regfile_seq_ctrl_regsel_encode.sv | 24 ++
 rtl/regfile_seq_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/regfile_seq_ctrl_pkg.sv
// Shared CPU constants for the register-file read sequencer: state encoding,
// opcode constants, read-mux select encoding and immediate sign extension.
package regfile_seq_ctrl_pkg;

    localparam int CPU_DATA_W   = 16;
    localparam int CPU_NUM_REGS = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ_A = 3'd1;
    localparam logic [2:0] ST_READ_B = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_READ_A = ST_READ_A,
        S_READ_B = ST_READ_B,
        S_EXEC   = ST_EXEC,
        S_WB     = ST_WB
    } seq_state_t;

    // Register-form compare: flags only, never written back.
    // The immediate form is the same code with bit 3 set.
    localparam logic [3:0] CPU_CMP_OP = 4'b0111;

    // Read-mux select 0 means "no register"; n+1 selects rn.
    localparam logic [4:0] REG_SEL_NONE = 5'd0;

    // Sign-extend the 8-bit immediate to the CPU data width.
    function automatic logic [CPU_DATA_W-1:0] sext_imm(input logic [7:0] imm);
        return {{(CPU_DATA_W-8){imm[7]}}, imm};
    endfunction

endpackage

// File: rtl/regfile_seq_ctrl_if.sv
// Decoder/datapath-facing bundle of the register-file sequencer.
// master: decoder + register file + ALU side; slave: the sequencer.
interface regfile_seq_ctrl_if
    import regfile_seq_ctrl_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int NUM_REGS = CPU_NUM_REGS
);
    logic                start;
    logic [3:0]          opcode;
    logic [3:0]          rdest;
    logic [3:0]          rsrc;
    logic [7:0]          imm;
    logic [DATA_W-1:0]   mux_out;
    logic [DATA_W-1:0]   alu_result;
    logic [4:0]          reg_select;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [3:0]          alu_op;
    logic [NUM_REGS-1:0] wb_en;
    logic [DATA_W-1:0]   wb_data;
    logic                busy;
    logic                done;

    modport master (
        output start, opcode, rdest, rsrc, imm, mux_out, alu_result,
        input  reg_select, op_a, op_b, alu_op, wb_en, wb_data, busy, done
    );

    modport slave (
        input  start, opcode, rdest, rsrc, imm, mux_out, alu_result,
        output reg_select, op_a, op_b, alu_op, wb_en, wb_data, busy, done
    );
endinterface

// File: rtl/regfile_seq_ctrl_regsel_encode.sv
// Register index encoder: 4-bit index + enable to the 5-bit read-mux select
// (0 = none, n+1 = rn) and to a one-hot register write enable.
module regsel_encode
    import regfile_seq_ctrl_pkg::*;
#(
    parameter int NUM_REGS = CPU_NUM_REGS
) (
    input  logic [3:0]          idx_i,
    input  logic                en_i,
    output logic [4:0]          sel_o,
    output logic [NUM_REGS-1:0] onehot_o
);

    // Both encodings collapse to all-zero when disabled.
    always_comb begin
        sel_o    = REG_SEL_NONE;
        onehot_o = '0;
        if (en_i) begin
            sel_o           = {1'b0, idx_i} + 5'd1;
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle sequencer for the shared register-file read mux and the ALU.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; latches opcode/rdest/rsrc (and imm -> op_b)
//   READ_A | mux selects rdest, op_a loads at cycle end
//   READ_B | mux selects rsrc, op_b loads at cycle end (register form only)
//   EXEC   | mux released, wb_data loads the ALU result at cycle end
//   WB     | done pulse, one-hot write enable unless the op is a compare
//
// All outputs are registered; reg_select and wb_en are encoded from the
// state being entered so they line up exactly with READ_A/READ_B and WB.
module regfile_seq_ctrl
    import regfile_seq_ctrl_pkg::*;
#(
    parameter int         DATA_W   = CPU_DATA_W,
    parameter int         NUM_REGS = CPU_NUM_REGS,
    parameter logic [3:0] CMP_OP   = CPU_CMP_OP
) (
    input  logic clk,
    input  logic reset_n,
    regfile_seq_ctrl_if.slave bus
);

    seq_state_t          state_q;
    logic [3:0]          opcode_q;
    logic [3:0]          rdest_q;
    logic [3:0]          rsrc_q;
    logic [DATA_W-1:0]   op_a_q;
    logic [DATA_W-1:0]   op_b_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic [4:0]          reg_select_q;
    logic [NUM_REGS-1:0] wb_en_q;
    logic                busy_q;
    logic                done_q;

    logic                accept;
    logic [3:0]          rd_idx;
    logic                rd_en;
    logic                wb_wen;
    logic [4:0]          reg_select_d;
    logic [NUM_REGS-1:0] wb_en_d;
    logic [NUM_REGS-1:0] rd_onehot_unused;
    logic [4:0]          wb_sel_unused;
    logic [DATA_W-1:0]   imm_ext;

    assign accept  = (state_q == S_IDLE) && bus.start;
    // On entry to READ_A the index still comes straight off the bus.
    assign rd_idx  = (state_q == S_IDLE) ? bus.rdest : rsrc_q;
    assign rd_en   = accept || ((state_q == S_READ_A) && !opcode_q[3]);
    assign wb_wen  = (state_q == S_EXEC) && (opcode_q[2:0] != CMP_OP[2:0]);
    assign imm_ext = DATA_W'($signed(sext_imm(bus.imm)));

    regsel_encode #(.NUM_REGS(NUM_REGS)) u_read_sel (
        .idx_i    (rd_idx),
        .en_i     (rd_en),
        .sel_o    (reg_select_d),
        .onehot_o (rd_onehot_unused)
    );

    regsel_encode #(.NUM_REGS(NUM_REGS)) u_wb_sel (
        .idx_i    (rdest_q),
        .en_i     (wb_wen),
        .sel_o    (wb_sel_unused),
        .onehot_o (wb_en_d)
    );

    // Sequencer FSM with registered datapath and handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            rdest_q      <= '0;
            rsrc_q       <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            wb_data_q    <= '0;
            reg_select_q <= REG_SEL_NONE;
            wb_en_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            reg_select_q <= reg_select_d;
            wb_en_q      <= wb_en_d;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        opcode_q <= bus.opcode;
                        rdest_q  <= bus.rdest;
                        rsrc_q   <= bus.rsrc;
                        if (bus.opcode[3]) begin
                            op_b_q <= imm_ext;
                        end
                        busy_q   <= 1'b1;
                        state_q  <= S_READ_A;
                    end
                end
                S_READ_A: begin
                    op_a_q  <= bus.mux_out;
                    state_q <= opcode_q[3] ? S_EXEC : S_READ_B;
                end
                S_READ_B: begin
                    op_b_q  <= bus.mux_out;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    wb_data_q <= bus.alu_result;
                    done_q    <= 1'b1;
                    state_q   <= S_WB;
                end
                S_WB: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.reg_select = reg_select_q;
    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.alu_op     = opcode_q;
    assign bus.wb_en      = wb_en_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
